// File: rtl/uart_receiver_oversampled_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_oversampled_if
//   Bundles the serial input, the received-word valid/ready holding register
//   and the status outputs of the UART receiver.
//
//   serial_connection  async RX line, idles high            (consumer -> rx)
//   data               received word, stable while valid     (rx -> consumer)
//   data_valid         holding register full                 (rx -> consumer)
//   data_ready         consumer accepts when valid && ready  (consumer -> rx)
//   parity_error       parity mismatch of held word          (rx -> consumer)
//   framing_error      1-cycle pulse, stop bit sampled low   (rx -> consumer)
//   overrun_error      1-cycle pulse, word dropped           (rx -> consumer)
//   busy               receiver FSM not idle                 (rx -> consumer)
//
//   modport master : the receiver itself
//   modport slave  : the byte consumer / line driver side
// ---------------------------------------------------------------------------
interface uart_receiver_oversampled_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 serial_connection;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  modport master (
    input  serial_connection,
    input  data_ready,
    output data,
    output data_valid,
    output parity_error,
    output framing_error,
    output overrun_error,
    output busy
  );

  modport slave (
    output serial_connection,
    output data_ready,
    input  data,
    input  data_valid,
    input  parity_error,
    input  framing_error,
    input  overrun_error,
    input  busy
  );
endinterface

// File: rtl/uart_receiver_oversampled.sv
// ---------------------------------------------------------------------------
// uart_receiver_oversampled
//   UART receive path running on the system clock. The line is synchronised
//   through two flops, the start bit is validated at mid-bit and every later
//   bit is sampled one bit period after the previous one. Supports 5..9 data
//   bits (LSB first), none/odd/even parity and 1 or 2 stop bits. Completed
//   words go into a valid/ready holding register; a word arriving while the
//   register is still full is dropped and flagged as an overrun.
//
//   clock   system clock, all logic on posedge
//   reset   asynchronous, active-high
//   bus     uart_receiver_oversampled_if.master (line, handshake, status)
// ---------------------------------------------------------------------------
module uart_receiver_oversampled #(
  parameter int CLOCKS_PER_BIT = 16,  // >= 4
  parameter int DATA_BITS      = 8,   // 5..9
  parameter int PARITY_MODE    = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS      = 1    // 1 or 2
) (
  input  logic                           clock,
  input  logic                           reset,
  uart_receiver_oversampled_if.master    bus
);

  localparam int                CW       = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0]     CNT_MID  = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]        IDX_LAST = 4'(DATA_BITS - 1);
  localparam logic              PAR_ODD  = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic                 sync1_q, rx_s_q;
  state_t               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_error_q, overrun_error_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q         <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      idx_q           <= '0;
      stop_idx_q      <= 1'b0;
      shift_q         <= '0;
      par_bad_q       <= 1'b0;
      done_q          <= 1'b0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      sync1_q         <= bus.serial_connection;
      rx_s_q          <= sync1_q;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      idx_q           <= idx_d;
      stop_idx_q      <= stop_idx_d;
      shift_q         <= shift_d;
      par_bad_q       <= par_bad_d;
      done_q          <= done_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    idx_d           = idx_q;
    stop_idx_d      = stop_idx_q;
    shift_d         = shift_q;
    par_bad_d       = par_bad_q;
    done_d          = 1'b0;
    data_d          = data_q;
    data_valid_d    = data_valid_q;
    parity_error_d  = parity_error_q;
    framing_error_d = 1'b0;
    overrun_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (bit_cnt_q == CNT_MID) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          // Shifting in from the top leaves the first (LSB) bit at index 0
          // after DATA_BITS samples.
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          idx_d     = idx_q + 4'd1;
          if (idx_q == IDX_LAST) begin
            par_bad_d  = 1'b0;
            stop_idx_d = 1'b0;
            state_d    = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      S_PARITY: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          // XOR of data and parity bit must be 1 for odd, 0 for even.
          par_bad_d = ((^shift_q) ^ rx_s_q) != PAR_ODD;
          state_d   = S_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      S_STOP: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          if (!rx_s_q) begin
            framing_error_d = 1'b1;
            state_d         = S_WAIT_HIGH;
          end else if (STOP_BITS == 2 && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            // Returning to IDLE at mid stop bit lets a back-to-back start
            // edge half a bit later be caught.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      S_WAIT_HIGH: begin
        // A held-low break must not look like a stream of start bits.
        if (rx_s_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Holding register: accept first, then a load in the same cycle wins.
    if (data_valid_q && bus.data_ready) data_valid_d = 1'b0;
    if (done_q) begin
      if (!data_valid_q || bus.data_ready) begin
        data_d         = shift_q;
        parity_error_d = par_bad_q;
        data_valid_d   = 1'b1;
      end else begin
        overrun_error_d = 1'b1;
      end
    end
  end

  assign bus.data          = data_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun_error = overrun_error_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver_oversampled.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver_oversampled
//   Bench for uart_receiver_oversampled configured as 8E1 at 16 clocks/bit.
//   A frame-level model predicts, from each frame sent and the consumer's
//   ready signal, what the holding register and status pulses must show on
//   every cycle; directed literal checks pin the model on known frames.
// ---------------------------------------------------------------------------
module tb_uart_receiver_oversampled;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int PM  = 2;
  localparam int SB  = 1;
  localparam int NP  = (PM != 0) ? 1 : 0;

  logic clock;
  logic reset;

  uart_receiver_oversampled_if #(.DATA_BITS(DB)) bus ();

  uart_receiver_oversampled #(
    .CLOCKS_PER_BIT (CPB),
    .DATA_BITS      (DB),
    .PARITY_MODE    (PM),
    .STOP_BITS      (SB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // Each sent frame is reduced to the clock edge at which its last stop bit
  // is judged: 2 sync flops + 1 clock to leave idle, half a bit to the start
  // sample, then one bit period per data/parity/stop bit.
  typedef struct {
    int             e;
    bit             good;
    logic [DB-1:0]  w;
    bit             perr;
  } ev_t;

  ev_t           evq[$];
  int            edge_no = 0;
  bit            m_valid = 0, m_fe = 0, m_ovr = 0, m_perr = 0, nv_m;
  logic [DB-1:0] m_data = '0;

  always @(posedge clock) begin
    edge_no = edge_no + 1;
    if (reset) begin
      evq.delete();
      m_valid = 0; m_data = '0; m_perr = 0; m_fe = 0; m_ovr = 0;
    end else begin
      nv_m  = m_valid && !bus.data_ready;
      m_fe  = 0;
      m_ovr = 0;
      if (evq.size() > 0) begin
        if (evq[0].good && evq[0].e == edge_no - 1) begin
          if (!m_valid || bus.data_ready) begin
            m_data = evq[0].w; m_perr = evq[0].perr; nv_m = 1;
          end else begin
            m_ovr = 1;
          end
          void'(evq.pop_front());
        end else if (!evq[0].good && evq[0].e == edge_no) begin
          m_fe = 1;
          void'(evq.pop_front());
        end
      end
      m_valid = nv_m;
    end
  end

  // ---------------- per-cycle compare ----------------
  int fe_seen = 0, ovr_seen = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.framing_error) fe_seen++;
      if (bus.overrun_error) ovr_seen++;
      check($sformatf("cycle_%0d", edge_no),
            {20'd0, bus.data_valid, bus.framing_error, bus.overrun_error,
             (m_valid ? bus.data : 8'h00), (m_valid ? bus.parity_error : 1'b0)},
            {20'd0, m_valid, m_fe, m_ovr, (m_valid ? m_data : 8'h00), (m_valid ? m_perr : 1'b0)});
    end
  end

  // ---------------- consumer ready driver ----------------
  int rdy_mode = 0;  // 0 low, 1 high, 2 random

  initial begin
    bus.data_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (rdy_mode)
        0:       bus.data_ready = 1'b0;
        1:       bus.data_ready = 1'b1;
        default: bus.data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    bus.serial_connection = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input bit par_ok,
                            input bit stop_ok, input int low_bits);
    ev_t ev;
    logic pbit;
    ev.e    = edge_no + 3 + CPB / 2 + (DB + NP + SB) * CPB;
    ev.good = stop_ok;
    ev.w    = w;
    ev.perr = (PM != 0) && !par_ok;
    evq.push_back(ev);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(w[i]);
    if (PM != 0) begin
      pbit = (^w) ^ (PM == 1);
      drive_bit(par_ok ? pbit : ~pbit);
    end
    if (stop_ok) begin
      repeat (SB) drive_bit(1'b1);
    end else begin
      bus.serial_connection = 1'b0;
      tick(low_bits * CPB);
      drive_bit(1'b1);
    end
  endtask

  task automatic accept_pulse();
    rdy_mode = 1;
    tick(1);
    rdy_mode = 0;
    tick(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int fe0, ovr0;

  initial begin
    reset = 1'b1;
    bus.serial_connection = 1'b1;
    tick(3);
    check("reset_data",  bus.data, 0);
    check("reset_valid", bus.data_valid, 0);
    check("reset_flags", {bus.parity_error, bus.framing_error, bus.overrun_error}, 0);
    check("reset_busy",  bus.busy, 0);
    reset = 1'b0;
    tick(4);

    // 1: 0xA5 held until a single ready pulse
    send_frame(8'hA5, 1, 1, 0);
    tick(2);
    check("t1_data",  bus.data, 8'hA5);
    check("t1_valid", bus.data_valid, 1);
    tick(20);
    check("t1_held", bus.data_valid, 1);
    accept_pulse();
    check("t1_accepted", bus.data_valid, 0);
    check("t1_data_kept", bus.data, 8'hA5);

    // 2: 4-clock glitch is a false start
    fe0 = fe_seen; ovr0 = ovr_seen;
    bus.serial_connection = 1'b0;
    tick(4);
    bus.serial_connection = 1'b1;
    tick(2);
    check("t2_busy_in_start", bus.busy, 1);
    tick(CPB);
    check("t2_back_idle", bus.busy, 0);
    check("t2_no_valid", bus.data_valid, 0);
    check("t2_no_pulses", {fe_seen - fe0, ovr_seen - ovr0}, 0);

    // 3: stop bit low, line held low 40 bits
    fe0 = fe_seen;
    fork
      send_frame(8'h3C, 1, 0, 40);
      begin
        tick((DB + NP + 1 + 20) * CPB);
        check("t3_busy_during_break", bus.busy, 1);
      end
    join
    for (int i = 0; i < 50 && bus.busy; i++) tick(1);
    check("t3_busy_after_high", bus.busy, 0);
    check("t3_fe_pulses", fe_seen - fe0, 1);
    check("t3_no_valid", bus.data_valid, 0);

    // 4: even parity, wrong then right parity bit on 0x07
    send_frame(8'h07, 0, 1, 0);
    tick(2);
    check("t4_data", bus.data, 8'h07);
    check("t4_valid", bus.data_valid, 1);
    check("t4_perr", bus.parity_error, 1);
    accept_pulse();
    send_frame(8'h07, 1, 1, 0);
    tick(2);
    check("t4_perr_ok", bus.parity_error, 0);
    check("t4_valid_ok", bus.data_valid, 1);
    accept_pulse();

    // 5: back-to-back with no consumer -> overrun
    ovr0 = ovr_seen;
    send_frame(8'h11, 1, 1, 0);
    send_frame(8'h22, 1, 1, 0);
    tick(2);
    check("t5_ovr_pulses", ovr_seen - ovr0, 1);
    check("t5_data_kept", bus.data, 8'h11);
    check("t5_valid", bus.data_valid, 1);
    accept_pulse();

    // 6: reset in the middle of data bit 4 of 0x55
    fe0 = fe_seen; ovr0 = ovr_seen;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h55 >> i) & 1));
    bus.serial_connection = 1'b1;
    tick(CPB / 2);
    reset = 1'b1;
    tick(2);
    check("t6_reset_outputs",
          {bus.data, bus.data_valid, bus.parity_error, bus.framing_error,
           bus.overrun_error, bus.busy}, 0);
    reset = 1'b0;
    tick(2 * CPB);
    send_frame(8'h9E, 1, 1, 0);
    tick(2);
    check("t6_data", bus.data, 8'h9E);
    check("t6_valid", bus.data_valid, 1);
    check("t6_no_errors", {bus.parity_error, 8'(fe_seen - fe0), 8'(ovr_seen - ovr0)}, 0);
    accept_pulse();

    // Randomised traffic with a random consumer
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) != 0), $urandom_range(1, 3));
      tick($urandom_range(0, 20));
    end
    rdy_mode = 1;
    tick(3 * CPB);
    check("end_queue_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
